// File: rtl/uart_tx_if.sv
// Byte handshake between a sender and the UART transmitter.
// The sender drives data/valid and the transmitter answers with ready.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// All line and status outputs are registered; bit timing from a CLK_FREQ/BAUD_RATE divider.
module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     uart_parity_enable,
    input  logic     uart_parity_type,
    uart_tx_if.slave link,
    output logic     tx,
    output logic     tx_busy,
    output logic     tx_done
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(DIV - 2);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t        state, state_nxt;
    logic [CW-1:0] baud, baud_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par_en, par_en_nxt;
    logic          par_bit, par_bit_nxt;
    logic          tx_nxt, ready, ready_nxt, busy_nxt, done_nxt;
    logic          bit_end;

    assign link.tx_ready = ready;
    assign bit_end       = (baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            par_en  <= par_en_nxt;
            par_bit <= par_bit_nxt;
            tx      <= tx_nxt;
            ready   <= ready_nxt;
            tx_busy <= busy_nxt;
            tx_done <= done_nxt;
        end
    end

    // tx and the status flags are computed one cycle ahead so they come straight from flops
    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        par_en_nxt  = par_en;
        par_bit_nxt = par_bit;
        tx_nxt      = tx;
        ready_nxt   = ready;
        busy_nxt    = tx_busy;
        done_nxt    = 1'b0;

        if (state != IDLE) begin
            baud_nxt = bit_end ? '0 : baud + 1'b1;
        end

        case (state)
            IDLE: begin
                if (link.tx_valid && ready) begin
                    state_nxt   = START;
                    baud_nxt    = '0;
                    shift_nxt   = link.tx_data;
                    par_en_nxt  = uart_parity_enable;
                    par_bit_nxt = parity_of(link.tx_data, uart_parity_type);
                    tx_nxt      = 1'b0;
                    ready_nxt   = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                    tx_nxt      = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = par_en ? PARITY : STOP;
                        tx_nxt    = par_en ? par_bit : 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = shift[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                done_nxt = (baud == BAUD_PRE);
                if (bit_end) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=10: table of frames plus reset, config-change and back-to-back sequences.
module tb_uart_tx;

    logic clk;
    logic rst_n;
    logic uart_parity_enable;
    logic uart_parity_type;
    logic tx, tx_busy, tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_if link_if ();

    uart_tx #(.CLK_FREQ(1_152_000), .BAUD_RATE(115200)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .uart_parity_enable (uart_parity_enable),
        .uart_parity_type   (uart_parity_type),
        .link               (link_if),
        .tx                 (tx),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       pen;
        logic       ptype;
        int         change_at;
        int         nslots;
        logic [10:0] frame;   // bit i = line level during bit slot i (slot 0 = start)
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int cyc, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (link_if.tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (link_if.tx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: tx_ready=%b after %0d cycles, expected 1", link_if.tx_ready, n);
        end
    endtask

    // Present a byte; returns at the negedge of the first start-bit cycle, tx_valid still high.
    task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptype);
        wait_ready();
        link_if.tx_data    = d;
        link_if.tx_valid   = 1'b1;
        uart_parity_enable = pen;
        uart_parity_type   = ptype;
        @(negedge clk);
    endtask

    // Called at cycle 1 of a frame; returns at the negedge of the cycle after the stop bit.
    task automatic watch_frame(input string name, input logic [10:0] frame, input int nslots,
                               input int change_at);
        int len;
        len = nslots * 10;
        for (int k = 1; k <= len; k++) begin
            chk({name, "_tx"}, k, tx, frame[(k - 1) / 10]);
            chk({name, "_done"}, k, tx_done, (k == len));
            if (k == 1 || k == len) begin
                chk({name, "_ready_low"}, k, link_if.tx_ready, 1'b0);
                chk({name, "_busy_high"}, k, tx_busy, 1'b1);
            end
            if (k == change_at) uart_parity_enable = 1'b0;
            if (k == 40 || k == 41) link_if.tx_valid = ~link_if.tx_valid;
            @(negedge clk);
        end
        chk({name, "_idle_tx"}, len + 1, tx, 1'b1);
        chk({name, "_idle_ready"}, len + 1, link_if.tx_ready, 1'b1);
        chk({name, "_idle_busy"}, len + 1, tx_busy, 1'b0);
        chk({name, "_idle_done"}, len + 1, tx_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"a5_even",    8'hA5, 1'b1, 1'b0, 0,  11, 11'b10101001010};
        vecs[1] = '{"a5_odd",     8'hA5, 1'b1, 1'b1, 0,  11, 11'b11101001010};
        vecs[2] = '{"3c_nopar",   8'h3C, 1'b0, 1'b0, 0,  10, 11'b01001111000};
        vecs[3] = '{"cfg_change", 8'h01, 1'b1, 1'b0, 30, 11, 11'b11000000010};

        rst_n              = 1'b0;
        link_if.tx_valid   = 1'b0;
        link_if.tx_data    = 8'h00;
        uart_parity_enable = 1'b0;
        uart_parity_type   = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            link_if.tx_valid   = 1'($urandom);
            link_if.tx_data    = 8'($urandom);
            uart_parity_enable = 1'($urandom);
            uart_parity_type   = 1'($urandom);
            #1;
            chk("rst_tx", i, tx, 1'b1);
            chk("rst_ready", i, link_if.tx_ready, 1'b1);
            chk("rst_busy", i, tx_busy, 1'b0);
            chk("rst_done", i, tx_done, 1'b0);
        end
        @(negedge clk);
        link_if.tx_valid = 1'b0;
        rst_n            = 1'b1;
        @(negedge clk);

        // Table of single frames
        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].data, vecs[v].pen, vecs[v].ptype);
            link_if.tx_valid = 1'b0;
            watch_frame(vecs[v].name, vecs[v].frame, vecs[v].nslots, vecs[v].change_at);
        end

        // Back-to-back with tx_valid held: 0x55 then 0xAA, parity off
        start_frame(8'h55, 1'b0, 1'b0);
        link_if.tx_data = 8'hAA;
        watch_frame("b2b_55", 11'b01010101010, 10, 0);
        @(negedge clk);
        link_if.tx_valid = 1'b0;
        watch_frame("b2b_aa", 11'b01101010100, 10, 0);
        for (int k = 0; k < 30; k++) begin
            chk("b2b_no_dup_tx", k, tx, 1'b1);
            chk("b2b_no_dup_busy", k, tx_busy, 1'b0);
            @(negedge clk);
        end

        // Reset asserted in the middle of the data bits
        start_frame(8'h00, 1'b0, 1'b0);
        link_if.tx_valid = 1'b0;
        repeat (24) @(negedge clk);
        chk("midrst_pre_tx", 25, tx, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 25, tx, 1'b1);
        chk("midrst_ready", 25, link_if.tx_ready, 1'b1);
        chk("midrst_busy", 25, tx_busy, 1'b0);
        chk("midrst_done", 25, tx_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("postrst_tx", k, tx, 1'b1);
            chk("postrst_ready", k, link_if.tx_ready, 1'b1);
            chk("postrst_busy", k, tx_busy, 1'b0);
        end

        // Frame after the aborted one still works
        start_frame(8'hA5, 1'b1, 1'b0);
        link_if.tx_valid = 1'b0;
        watch_frame("after_rst", 11'b10101001010, 11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
